hazard_ctrl: RTL and testbench



---
 rtl/hazard_pkg.sv | 18 +
 rtl/md_busy_fsm.sv | 61 ++++++
 rtl/hazard_ctrl.sv | 118 +++++++++++
 tb/tb_hazard_ctrl.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared constants and types for the MIPS hazard/control unit.
// Forward-select encodings, mult/div FSM states, zero register.
package hazard_pkg;

  localparam int REG_AW_DEF = 5;

  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_W  = 2'b01;
  localparam logic [1:0] FWD_M  = 2'b10;

  localparam logic [REG_AW_DEF-1:0] REG_ZERO = '0;

  typedef enum logic {
    MD_IDLE,
    MD_BUSY
  } md_state_t;

endpackage

// File: rtl/md_busy_fsm.sv
// Mult/div occupancy tracker: IDLE/BUSY state, down-counter, busy flag.
// Ports: clk, rst_n, start_i, div_i (1=div), busy_o.
module md_busy_fsm
  import hazard_pkg::*;
#(
  parameter int MULT_CYCLES = 4,
  parameter int DIV_CYCLES  = 16,
  parameter int CNT_W       = 5
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start_i,
  input  logic div_i,
  output logic busy_o
);

  localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MULT_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  md_state_t        state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             busy_q;

  // The start cycle itself counts toward occupancy, so the
  // counter is loaded with N-1 and BUSY lasts N-1 cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= MD_IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        MD_IDLE: begin
          if (start_i) begin
            state_q <= MD_BUSY;
            busy_q  <= 1'b1;
            cnt_q   <= div_i ? DIV_LOAD : MUL_LOAD;
          end
        end
        MD_BUSY: begin
          if (cnt_q == CNT_ONE) begin
            state_q <= MD_IDLE;
            busy_q  <= 1'b0;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q - CNT_ONE;
          end
        end
        default: begin
          state_q <= MD_IDLE;
          busy_q  <= 1'b0;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign busy_o = busy_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard/forwarding control for the 5-stage MIPS pipeline.
// Ports: D/E/M/W register ids and write enables in; stall/flush,
// forward selects and md_busy out. HAZARD_STATS_EN adds
// stall_cnt/flush_cnt saturating event counters.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int REG_AW      = 5,
  parameter int MULT_CYCLES = 4,
  parameter int DIV_CYCLES  = 16,
  parameter int CNT_W       = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [REG_AW-1:0] rsD,
  input  logic [REG_AW-1:0] rtD,
  input  logic [REG_AW-1:0] rsE,
  input  logic [REG_AW-1:0] rtE,
  input  logic [REG_AW-1:0] writeregE,
  input  logic [REG_AW-1:0] writeregM,
  input  logic [REG_AW-1:0] writeregW,
  input  logic              regwriteE,
  input  logic              regwriteM,
  input  logic              regwriteW,
  input  logic              memtoregE,
  input  logic              memtoregM,
  input  logic              branchD,
  input  logic              jumpregD,
  input  logic              pcsrcD,
  input  logic              md_startE,
  input  logic              md_divE,
  input  logic              md_useD,
  output logic              stallF,
  output logic              stallD,
  output logic              flushD,
  output logic              flushE,
  output logic              forwardAD,
  output logic              forwardBD,
  output logic [1:0]        forwardAE,
  output logic [1:0]        forwardBE,
  output logic              md_busy
`ifdef HAZARD_STATS_EN
  ,
  output logic [31:0]       stall_cnt,
  output logic [31:0]       flush_cnt
`endif
);

  localparam logic [REG_AW-1:0] RZ = REG_AW'(REG_ZERO);

  logic mwr, wwr, ewr, mld;
  logic lwstall, brstall, mdstall, stall;

  md_busy_fsm #(
    .MULT_CYCLES(MULT_CYCLES),
    .DIV_CYCLES (DIV_CYCLES),
    .CNT_W      (CNT_W)
  ) u_md (
    .clk    (clk),
    .rst_n  (rst_n),
    .start_i(md_startE),
    .div_i  (md_divE),
    .busy_o (md_busy)
  );

  assign mwr = regwriteM && (writeregM != RZ);
  assign wwr = regwriteW && (writeregW != RZ);
  assign ewr = regwriteE && (writeregE != RZ);
  assign mld = memtoregM && (writeregM != RZ);

  always_comb begin
    forwardAE = FWD_RF;
    if (mwr && writeregM == rsE)      forwardAE = FWD_M;
    else if (wwr && writeregW == rsE) forwardAE = FWD_W;
    forwardBE = FWD_RF;
    if (mwr && writeregM == rtE)      forwardBE = FWD_M;
    else if (wwr && writeregW == rtE) forwardBE = FWD_W;
  end

  assign forwardAD = (rsD != RZ) && regwriteM && (writeregM == rsD);
  assign forwardBD = (rtD != RZ) && regwriteM && (writeregM == rtD);

  assign lwstall = memtoregE && (rtE != RZ)
                && (rtE == rsD || rtE == rtD);

  // jr/jalr only read rs; branches compare rs and rt.
  logic hit_rs, hit_rt;
  assign hit_rs = (ewr && writeregE == rsD)
               || (mld && writeregM == rsD);
  assign hit_rt = (ewr && writeregE == rtD)
               || (mld && writeregM == rtD);
  assign brstall = (branchD && (hit_rs || hit_rt))
                || (jumpregD && hit_rs);

  assign mdstall = md_useD && (md_busy || md_startE);

  assign stall  = lwstall | brstall | mdstall;
  assign stallF = stall;
  assign stallD = stall;
  assign flushE = stall;
  // IF/ID clear beats stall; suppress it so a held D isn't lost.
  assign flushD = pcsrcD && !stall;

`ifdef HAZARD_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stallD && stall_cnt != 32'hFFFF_FFFF)
        stall_cnt <= stall_cnt + 32'd1;
      if (flushD && flush_cnt != 32'hFFFF_FFFF)
        flush_cnt <= flush_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Testbench for hazard_ctrl: directed steps plus random cycles
// checked against a behavioural model of the hazard rules.
module tb_hazard_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic [4:0] rsD, rtD, rsE, rtE;
  logic [4:0] writeregE, writeregM, writeregW;
  logic       regwriteE, regwriteM, regwriteW;
  logic       memtoregE, memtoregM;
  logic       branchD, jumpregD, pcsrcD;
  logic       md_startE, md_divE, md_useD;
  logic       stallF, stallD, flushD, flushE;
  logic       forwardAD, forwardBD;
  logic [1:0] forwardAE, forwardBE;
  logic       md_busy;

  int checks = 0;
  int errors = 0;
  int busy_left = 0;

  hazard_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .rsD(rsD), .rtD(rtD), .rsE(rsE), .rtE(rtE),
    .writeregE(writeregE), .writeregM(writeregM),
    .writeregW(writeregW),
    .regwriteE(regwriteE), .regwriteM(regwriteM),
    .regwriteW(regwriteW),
    .memtoregE(memtoregE), .memtoregM(memtoregM),
    .branchD(branchD), .jumpregD(jumpregD), .pcsrcD(pcsrcD),
    .md_startE(md_startE), .md_divE(md_divE), .md_useD(md_useD),
    .stallF(stallF), .stallD(stallD), .flushD(flushD),
    .flushE(flushE),
    .forwardAD(forwardAD), .forwardBD(forwardBD),
    .forwardAE(forwardAE), .forwardBE(forwardBE),
    .md_busy(md_busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] ref_fwdE(input logic [4:0] r);
    if (regwriteM && writeregM != 0 && writeregM == r) return 2;
    if (regwriteW && writeregW != 0 && writeregW == r) return 1;
    return 0;
  endfunction

  function automatic logic reads_pending(input logic [4:0] r);
    return (regwriteE && writeregE != 0 && writeregE == r)
        || (memtoregM && writeregM != 0 && writeregM == r);
  endfunction

  task automatic check_model();
    logic lw, br, md, st;
    #1;
    lw = memtoregE && rtE != 0 && (rtE == rsD || rtE == rtD);
    br = (branchD && (reads_pending(rsD) || reads_pending(rtD)))
      || (jumpregD && reads_pending(rsD));
    md = md_useD && (busy_left > 0 || md_startE);
    st = lw || br || md;
    chk("stallF", 32'(stallF), 32'(st));
    chk("stallD", 32'(stallD), 32'(st));
    chk("flushE", 32'(flushE), 32'(st));
    chk("flushD", 32'(flushD), 32'(pcsrcD && !st));
    chk("fwdAD", 32'(forwardAD),
        32'(rsD != 0 && regwriteM && writeregM == rsD));
    chk("fwdBD", 32'(forwardBD),
        32'(rtD != 0 && regwriteM && writeregM == rtD));
    chk("fwdAE", 32'(forwardAE), 32'(ref_fwdE(rsE)));
    chk("fwdBE", 32'(forwardBE), 32'(ref_fwdE(rtE)));
    chk("md_busy", 32'(md_busy), 32'(busy_left > 0));
  endtask

  // Occupancy model: N cycles total including the start cycle.
  task automatic tick();
    @(posedge clk);
    if (!rst_n) busy_left = 0;
    else if (busy_left > 0) busy_left--;
    else if (md_startE) busy_left = (md_divE ? 16 : 4) - 1;
    #1;
  endtask

  task automatic clear_in();
    rsD = 0; rtD = 0; rsE = 0; rtE = 0;
    writeregE = 0; writeregM = 0; writeregW = 0;
    regwriteE = 0; regwriteM = 0; regwriteW = 0;
    memtoregE = 0; memtoregM = 0;
    branchD = 0; jumpregD = 0; pcsrcD = 0;
    md_startE = 0; md_divE = 0; md_useD = 0;
  endtask

  initial begin
    rst_n = 1'b0;
    clear_in();
    #1;
    chk("rst_busy", 32'(md_busy), 32'd0);
    chk("rst_stall", 32'(stallD), 32'd0);
    tick(); tick();
    rst_n = 1'b1;
    tick();
    check_model();

    // Forward priority M over W, zero register never forwards.
    writeregM = 8; writeregW = 8; regwriteM = 1; regwriteW = 1;
    rsE = 8;
    #1 chk("fwd_M", 32'(forwardAE), 32'd2);
    regwriteM = 0;
    #1 chk("fwd_W", 32'(forwardAE), 32'd1);
    writeregM = 0; writeregW = 0; regwriteM = 1;
    #1 chk("fwd_RF", 32'(forwardAE), 32'd0);
    check_model();
    tick();

    // Load-use.
    clear_in();
    memtoregE = 1; rtE = 9; rsD = 9;
    #1;
    chk("lw_stallF", 32'(stallF), 32'd1);
    chk("lw_stallD", 32'(stallD), 32'd1);
    chk("lw_flushE", 32'(flushE), 32'd1);
    chk("lw_flushD", 32'(flushD), 32'd0);
    memtoregE = 0;
    #1 chk("lw_clear", 32'(stallD), 32'd0);
    tick();

    // Branch operand produced in E, then forwarded from M.
    clear_in();
    branchD = 1; rsD = 4; regwriteE = 1; writeregE = 4;
    #1 chk("br_stall", 32'(stallD), 32'd1);
    tick();
    regwriteE = 0; writeregE = 0;
    writeregM = 4; regwriteM = 1; memtoregM = 0;
    #1;
    chk("br_nostall", 32'(stallD), 32'd0);
    chk("br_fwdAD", 32'(forwardAD), 32'd1);
    check_model();
    tick();

    // Redirect vs stall.
    clear_in();
    pcsrcD = 1;
    #1 chk("redir_flush", 32'(flushD), 32'd1);
    memtoregE = 1; rtE = 3; rtD = 3;
    #1;
    chk("redir_hold_fD", 32'(flushD), 32'd0);
    chk("redir_hold_sD", 32'(stallD), 32'd1);
    tick();

    // Div then mult occupancy with a HI/LO reader waiting in D.
    clear_in();
    md_useD = 1; md_divE = 1;
    for (int c = 0; c <= 16; c++) begin
      md_startE = (c == 0);
      #1;
      chk("div_stall", 32'(stallD), 32'(c <= 15));
      chk("div_busy", 32'(md_busy), 32'(c >= 1 && c <= 15));
      tick();
    end
    md_divE = 0;
    for (int c = 0; c <= 4; c++) begin
      md_startE = (c == 0);
      #1;
      chk("mul_stall", 32'(stallD), 32'(c <= 3));
      chk("mul_busy", 32'(md_busy), 32'(c >= 1 && c <= 3));
      tick();
    end

    // Reset in the middle of a div.
    clear_in();
    md_startE = 1; md_divE = 1;
    tick();
    md_startE = 0;
    for (int c = 1; c < 5; c++) tick();
    chk("mid_busy", 32'(md_busy), 32'd1);
    #2 rst_n = 1'b0;
    #1 chk("rst_mid_busy", 32'(md_busy), 32'd0);
    tick();
    rst_n = 1'b1;
    md_useD = 1;
    #1 chk("rst_mid_nostall", 32'(stallD), 32'd0);
    check_model();
    tick();

    // Random cycles against the model.
    for (int i = 0; i < 400; i++) begin
      logic [2:0] bj;
      rsD = 5'($urandom_range(0, 3)); rtD = 5'($urandom_range(0, 3));
      rsE = 5'($urandom_range(0, 3)); rtE = 5'($urandom_range(0, 3));
      writeregE = 5'($urandom_range(0, 3));
      writeregM = 5'($urandom_range(0, 3));
      writeregW = 5'($urandom_range(0, 3));
      regwriteE = 1'($urandom); regwriteM = 1'($urandom);
      regwriteW = 1'($urandom);
      memtoregE = 1'($urandom); memtoregM = 1'($urandom);
      bj = 3'($urandom_range(0, 2));
      branchD = (bj == 1); jumpregD = (bj == 2);
      pcsrcD = 1'($urandom);
      md_startE = ($urandom_range(0, 9) == 0);
      md_divE = 1'($urandom);
      md_useD = 1'($urandom);
      check_model();
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
